// File: rtl/io_map_pkg.sv
// I/O window map shared by io_ctrl and the datapath io_sel mux.
// Holds the window base, register offsets, keyboard FSM states and status bits.
package io_map_pkg;

   localparam logic [31:0] IO_BASE      = 32'hFFFF_FC00;
   localparam logic [7:0]  TUBE_OFS     = 8'h60;
   localparam logic [7:0]  KBD_DATA_OFS = 8'h70;
   localparam logic [7:0]  KBD_STAT_OFS = 8'h74;
   localparam logic [7:0]  CYCLE_OFS    = 8'h78;

   localparam int STAT_PENDING = 0;
   localparam int STAT_WAIT    = 1;
   localparam int STAT_OVERRUN = 2;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_KEY = 1'b1
   } kbd_state_t;

   function automatic logic io_window_hit(input logic [31:0] addr);
      return addr[31:8] == IO_BASE[31:8];
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// single-cycle rising-edge pulse. A held button yields exactly one pulse.
module btn_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: tube register, keyboard entry word with
// stall-until-available loads, and a free-running cycle counter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no keyboard load outstanding
//   WAIT_KEY | datapath is stalled on a keyboard-data load, no word yet
module io_ctrl
   import io_map_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_wdata,
   output logic        io_sel,
   output logic [31:0] io_rdata,
   output logic        stall,
   input  logic [31:0] keyboard_in,
   input  logic        keyboard_finish,
   output logic [31:0] reg_map_tube
);

   kbd_state_t  state, state_nxt;
   logic [31:0] kbd_data;
   logic [31:0] cycle;
   logic        pending;
   logic        overrun;
   logic        kfin_rise;
   logic [7:0]  ofs;
   logic        rd_kbd, rd_stat, consume;
   logic        wr_tube, wr_cycle;
   logic [31:0] status;

   btn_edge_sync u_kfin_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (keyboard_finish),
      .rise  (kfin_rise)
   );

   assign ofs      = mem_addr[7:0];
   assign io_sel   = (mem_rd | mem_wr) & io_window_hit(mem_addr);
   assign rd_kbd   = mem_rd & io_sel & (ofs == KBD_DATA_OFS);
   assign rd_stat  = mem_rd & io_sel & (ofs == KBD_STAT_OFS);
   assign consume  = rd_kbd & pending;
   assign wr_tube  = mem_wr & io_sel & (ofs == TUBE_OFS);
   assign wr_cycle = mem_wr & io_sel & (ofs == CYCLE_OFS);

   // Stall comes straight from the request and pending flag so a word that
   // lands this cycle releases the pipeline without waiting on the FSM.
   assign stall = rst_n & rd_kbd & ~pending;

   always_comb begin
      status               = '0;
      status[STAT_PENDING] = pending;
      status[STAT_WAIT]    = (state == WAIT_KEY);
      status[STAT_OVERRUN] = overrun;
   end

   always_comb begin
      io_rdata = '0;
      if (io_sel) begin
         case (ofs)
            TUBE_OFS:     io_rdata = reg_map_tube;
            KBD_DATA_OFS: io_rdata = kbd_data;
            KBD_STAT_OFS: io_rdata = status;
            CYCLE_OFS:    io_rdata = cycle;
            default:      io_rdata = '0;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (stall) state_nxt = WAIT_KEY;
         WAIT_KEY: if (!rd_kbd || pending) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A capture landing on a consuming read refills pending; overrun only
   // flags a word that was lost without ever being read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kbd_data <= '0;
         pending  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (kfin_rise) begin
            kbd_data <= keyboard_in;
            pending  <= 1'b1;
         end else if (consume) begin
            pending  <= 1'b0;
         end
         if (kfin_rise && pending && !consume) overrun <= 1'b1;
         else if (rd_stat)                     overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_map_tube <= '0;
         cycle        <= '0;
      end else begin
         if (wr_tube) reg_map_tube <= mem_wdata;
         if (wr_cycle) cycle <= '0;
         else          cycle <= cycle + 32'd1;
      end
   end

endmodule
